// File: rtl/arb_pkg.sv
// Shared definitions for the weighted round-robin session arbiter family:
// FSM state encoding, default parameter values and picker sizing helper.
package arb_pkg;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_WEIGHT_W = 3;
  localparam int DEF_TMO_W    = 8;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // Index width for an n-way picker; never narrower than one bit.
  function automatic int pick_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// modulo N. Returns the one-hot winner, its index and a found flag.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N     = DEF_N_REQ,
  parameter int IDX_W = pick_idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Walk positions in rotated order (ptr, ptr+1, ...); the first hit wins.
  // This folds rotate, lowest-bit priority and rotate-back into one pass.
  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = i + int'(ptr);
      if (j >= N) begin
        j = j - N;
      end
      if (req[j] && !any) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/wrr_session_arbiter.sv
// Weighted round-robin arbiter with session hold. An owner keeps the
// resource until session_done; it may renew up to weight sessions, and a
// watchdog reclaims sessions that never end. All outputs come from flops.
module wrr_session_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int TMO_W    = DEF_TMO_W,
  parameter int IDX_W    = pick_idx_w(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_an,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*WEIGHT_W-1:0] weight,
  input  logic [TMO_W-1:0]          tmo_cfg,
  input  logic                      session_done,
  output logic [N_REQ-1:0]          grant,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      grant_vld,
  output logic                      tmo_evt
);

  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [IDX_W-1:0]    ONE_I    = IDX_W'(1);
  localparam logic [WEIGHT_W-1:0] ONE_W    = WEIGHT_W'(1);
  localparam logic [TMO_W-1:0]    ONE_T    = TMO_W'(1);

  arb_state_e          state_reg;
  logic [IDX_W-1:0]    ptr_reg;
  logic [WEIGHT_W-1:0] credit_reg;
  logic [TMO_W-1:0]    wdog_reg;

  // Effective per-requester budget: a zero weight still grants one session.
  logic [WEIGHT_W-1:0] eff_weight [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_weight
      assign eff_weight[gi] = (weight[gi*WEIGHT_W +: WEIGHT_W] == '0)
                              ? ONE_W : weight[gi*WEIGHT_W +: WEIGHT_W];
    end
  endgenerate

  logic [IDX_W-1:0] ptr_after_owner;
  logic [N_REQ-1:0] pick_req;
  logic [IDX_W-1:0] pick_ptr;
  logic [N_REQ-1:0] pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             owner_req;
  logic             timeout;
  logic             session_end;
  logic             renew;

  // Pointer wraps explicitly so non-power-of-2 N_REQ never points past the end.
  assign ptr_after_owner = (grant_idx == LAST_IDX) ? '0 : grant_idx + ONE_I;

  // While owning, the picker looks past the owner with the owner masked out;
  // from idle it scans the raw request vector from the stored pointer.
  always_comb begin
    pick_req = req;
    pick_ptr = ptr_reg;
    if (state_reg == OWN) begin
      pick_req = req & ~grant;
      pick_ptr = ptr_after_owner;
    end
  end

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // session_done outranks an expiring watchdog in the same cycle.
  assign owner_req   = |(req & grant);
  assign timeout     = (state_reg == OWN) && (tmo_cfg != '0) &&
                       (wdog_reg == tmo_cfg - ONE_T) && !session_done;
  assign session_end = (state_reg == OWN) && (session_done || timeout);
  assign renew       = (credit_reg > ONE_W) && owner_req && !timeout;

  // Arbitration FSM with credit, watchdog, pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      credit_reg <= '0;
      wdog_reg   <= '0;
      grant      <= '0;
      grant_idx  <= '0;
      grant_vld  <= 1'b0;
      tmo_evt    <= 1'b0;
    end else begin
      tmo_evt <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            grant      <= pick_grant;
            grant_idx  <= pick_idx;
            grant_vld  <= 1'b1;
            credit_reg <= eff_weight[pick_idx];
            wdog_reg   <= '0;
            state_reg  <= OWN;
          end
        end
        OWN: begin
          if (!session_end) begin
            if (wdog_reg != '1) begin
              wdog_reg <= wdog_reg + ONE_T;
            end
          end else begin
            tmo_evt  <= timeout;
            wdog_reg <= '0;
            if (renew) begin
              credit_reg <= credit_reg - ONE_W;
            end else begin
              ptr_reg <= ptr_after_owner;
              if (pick_any) begin
                grant      <= pick_grant;
                grant_idx  <= pick_idx;
                credit_reg <= eff_weight[pick_idx];
              end else if (owner_req) begin
                credit_reg <= eff_weight[grant_idx];
              end else begin
                grant      <= '0;
                grant_idx  <= '0;
                grant_vld  <= 1'b0;
                credit_reg <= '0;
                state_reg  <= IDLE;
              end
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wrr_session_arbiter.sv
// Directed bench for wrr_session_arbiter (N_REQ=4, WEIGHT_W=3, TMO_W=8).
// Expected values are hand-derived from the arbitration rules.
module tb_wrr_session_arbiter;

  logic        clk = 1'b0;
  logic        rst_an;
  logic [3:0]  req;
  logic [11:0] weight;
  logic [7:0]  tmo_cfg;
  logic        session_done;
  logic [3:0]  grant;
  logic [1:0]  grant_idx;
  logic        grant_vld;
  logic        tmo_evt;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  wrr_session_arbiter dut (
    .clk          (clk),
    .rst_an       (rst_an),
    .req          (req),
    .weight       (weight),
    .tmo_cfg      (tmo_cfg),
    .session_done (session_done),
    .grant        (grant),
    .grant_idx    (grant_idx),
    .grant_vld    (grant_vld),
    .tmo_evt      (tmo_evt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one clock; sample and drive 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_an       = 1'b0;
    req          = 4'b0000;
    weight       = {4{3'd1}};
    tmo_cfg      = 8'd0;
    session_done = 1'b0;

    // Reset state
    #12;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_idx",   32'(grant_idx), 32'h0);
    chk("rst_vld",   32'(grant_vld), 32'h0);
    chk("rst_tmo",   32'(tmo_evt), 32'h0);
    rst_an = 1'b1;
    step();

    // First grant from ptr=0, then seamless handover
    req = 4'b1010;
    step();
    chk("first_grant", 32'(grant), 32'h2);
    chk("first_idx",   32'(grant_idx), 32'h1);
    chk("first_vld",   32'(grant_vld), 32'h1);
    session_done = 1'b1;
    step();
    chk("handover_grant", 32'(grant), 32'h8);
    chk("handover_idx",   32'(grant_idx), 32'h3);
    req = 4'b0000;
    step();
    chk("drain_grant", 32'(grant), 32'h0);
    chk("drain_vld",   32'(grant_vld), 32'h0);
    session_done = 1'b0;

    // Weighted renew: requester 0 owns three sessions (ptr back at 0)
    weight = {3'd1, 3'd1, 3'd1, 3'd3};
    req    = 4'b0011;
    step();
    chk("wt_grant0", 32'(grant), 32'h1);
    for (int k = 0; k < 2; k++) begin
      session_done = 1'b1;
      step();
      session_done = 1'b0;
      chk($sformatf("wt_renew%0d", k), 32'(grant), 32'h1);
      step();
      chk($sformatf("wt_hold%0d", k), 32'(grant), 32'h1);
    end
    session_done = 1'b1;
    step();
    chk("wt_handover", 32'(grant), 32'h2);
    req = 4'b0000;
    step();
    session_done = 1'b0;
    chk("wt_idle", 32'(grant_vld), 32'h0);

    // Fairness from a fresh reset: 0,1,2,3,0,1,2,3
    weight = {4{3'd1}};
    rst_an = 1'b0;
    #2;
    rst_an = 1'b1;
    req = 4'b1111;
    step();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("fair%0d", k), 32'(grant_idx), 32'(k % 4));
      if (k < 7) begin
        session_done = 1'b1;
        step();
      end
    end
    req = 4'b0000;
    session_done = 1'b1;
    step();
    session_done = 1'b0;
    chk("fair_idle", 32'(grant), 32'h0);

    // Timeout hands over to the next requester (ptr=0)
    tmo_cfg = 8'd5;
    req     = 4'b0011;
    step();
    chk("tmo_own0", 32'(grant), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("tmo_hold%0d", k), 32'(grant), 32'h1);
      chk($sformatf("tmo_quiet%0d", k), 32'(tmo_evt), 32'h0);
    end
    step();
    chk("tmo_next_grant", 32'(grant), 32'h2);
    chk("tmo_evt_pulse",  32'(tmo_evt), 32'h1);
    step();
    chk("tmo_evt_single", 32'(tmo_evt), 32'h0);
    chk("tmo_own1",       32'(grant), 32'h2);

    // Timeout with nobody requesting revokes to zero
    req = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("tmo_hold1_%0d", k), 32'(grant), 32'h2);
    end
    step();
    chk("tmo_zero_grant", 32'(grant), 32'h0);
    chk("tmo_zero_vld",   32'(grant_vld), 32'h0);
    chk("tmo_zero_evt",   32'(tmo_evt), 32'h1);
    step();
    chk("tmo_zero_evt_off", 32'(tmo_evt), 32'h0);

    // session_done coincident with expiry wins; no tmo_evt (ptr=2)
    req = 4'b0011;
    step();
    chk("tie_own0", 32'(grant), 32'h1);
    for (int k = 0; k < 4; k++) begin
      step();
    end
    session_done = 1'b1;
    step();
    session_done = 1'b0;
    chk("tie_grant", 32'(grant), 32'h2);
    chk("tie_evt",   32'(tmo_evt), 32'h0);
    step();
    chk("tie_evt_after", 32'(tmo_evt), 32'h0);
    tmo_cfg      = 8'd0;
    req          = 4'b0000;
    session_done = 1'b1;
    step();
    session_done = 1'b0;

    // Sole requester is re-granted, then idles when it drops (ptr=2)
    req = 4'b0100;
    step();
    chk("sole_grant", 32'(grant), 32'h4);
    session_done = 1'b1;
    step();
    session_done = 1'b0;
    chk("sole_regrant", 32'(grant), 32'h4);
    chk("sole_vld",     32'(grant_vld), 32'h1);
    step();
    chk("sole_hold", 32'(grant), 32'h4);
    req          = 4'b0000;
    session_done = 1'b1;
    step();
    session_done = 1'b0;
    chk("sole_idle_grant", 32'(grant), 32'h0);
    chk("sole_idle_vld",   32'(grant_vld), 32'h0);

    // Async reset mid-session (ptr=3 before reset)
    req = 4'b0010;
    step();
    chk("ar_own", 32'(grant), 32'h2);
    #2;
    rst_an = 1'b0;
    #1;
    chk("ar_grant", 32'(grant), 32'h0);
    chk("ar_vld",   32'(grant_vld), 32'h0);
    chk("ar_tmo",   32'(tmo_evt), 32'h0);
    chk("ar_idx",   32'(grant_idx), 32'h0);
    rst_an = 1'b1;
    req    = 4'b1010;
    step();
    chk("ar_restart_grant", 32'(grant), 32'h2);
    chk("ar_restart_idx",   32'(grant_idx), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
